// File: rtl/router_rx_port.sv
// -----------------------------------------------------------------------------
// router_rx_port
//
// Per-port serial receiver on the router input side. Deserialises the
// frame_n/valid_n/din protocol into tagged entries {sof, eof, data} and
// buffers them in a show-ahead FIFO for the crossbar arbiter.
//
// Frame format: frame_n_i falls and the same cycle carries address bit 0;
// ADDR_W address bits LSB-first (one per cycle), PAD_CYCLES pad cycles with
// valid_n_i high, then payload bits LSB-first qualified by valid_n_i=0. The
// last payload bit is the one sampled with frame_n_i=1.
//
// Ports:
//   clk        port clock, rising edge
//   rst        asynchronous active-high reset
//   din_i      serial data bit
//   frame_n_i  active-low frame envelope
//   valid_n_i  active-low payload bit qualifier
//   busy_n_o   active-low back-pressure (registered, count >= FIFO_DEPTH-1)
//   rd_en_i    pop the head entry (ignored when empty)
//   rd_data_o  head entry {sof, eof, data}; valid when empty_o=0, else 0
//   empty_o    FIFO empty
//   err_o      one-cycle pulse on protocol error
//   ovf_o      sticky overflow flag, cleared only by rst
//
// Optional build macro RX_STATS_EN adds:
//   pkt_cnt_o[15:0]  packets completed with an eof entry (wraps)
//   err_cnt_o[7:0]   err_o pulses (saturates at 255)
//
// Parameter assumptions: 2 <= ADDR_W <= DATA_W, PAD_CYCLES >= 1,
// FIFO_DEPTH a power of two >= 4, all phase lengths below 256.
// -----------------------------------------------------------------------------
module router_rx_port #(
    parameter int ADDR_W     = 4,
    parameter int PAD_CYCLES = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_i,
    input  logic              frame_n_i,
    input  logic              valid_n_i,
    output logic              busy_n_o,
    input  logic              rd_en_i,
    output logic [DATA_W+1:0] rd_data_o,
    output logic              empty_o,
    output logic              err_o,
    output logic              ovf_o
`ifdef RX_STATS_EN
    ,
    output logic [15:0]       pkt_cnt_o,
    output logic [7:0]        err_cnt_o
`endif
);

    localparam int ENTRY_W = DATA_W + 2;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PAD,
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t               state_reg, state_next;
    // Shared phase counter: address bits, pad cycles or payload bits.
    logic [7:0]           cnt_reg, cnt_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next, addr_shift;
    logic [DATA_W-1:0]    data_reg, data_next, data_shift;
    logic [DATA_W-1:0]    addr_ext;

    logic                 push;
    logic [ENTRY_W-1:0]   push_entry;
    logic                 err_det;
    logic                 ovf_det;

    logic                 err_reg;
    logic                 ovf_reg;
    logic                 busy_n_reg;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic                 pop;
    logic                 can_push;

    // A push into a full FIFO is only accepted when a pop frees a slot in
    // the same cycle (full implies non-empty, so rd_en_i alone is enough).
    assign pop      = rd_en_i && (count_reg != '0);
    assign can_push = (count_reg != CNT_W'(FIFO_DEPTH)) || pop;

    // LSB-first: new bit enters at the top, so after W shifts the first bit
    // sits at bit 0.
    assign addr_shift = {din_i, addr_reg[ADDR_W-1:1]};
    assign data_shift = {din_i, data_reg[DATA_W-1:1]};

    always_comb begin
        addr_ext               = '0;
        addr_ext[ADDR_W-1:0]   = addr_shift;
    end

    // -------------------------------------------------------------------------
    // Receive FSM: next state and push/error decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        push       = 1'b0;
        push_entry = '0;
        err_det    = 1'b0;
        ovf_det    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // The start cycle already carries address bit 0.
                if (!frame_n_i) begin
                    addr_next  = addr_shift;
                    cnt_next   = 8'd1;
                    state_next = S_ADDR;
                end
            end

            S_ADDR: begin
                if (frame_n_i) begin
                    err_det    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    addr_next = addr_shift;
                    if (cnt_reg == 8'(ADDR_W - 1)) begin
                        cnt_next   = '0;
                        push_entry = {2'b10, addr_ext};
                        if (can_push) begin
                            push       = 1'b1;
                            state_next = S_PAD;
                        end else begin
                            ovf_det    = 1'b1;
                            state_next = S_DROP;
                        end
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end

            S_PAD: begin
                if (frame_n_i || !valid_n_i) begin
                    err_det    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else if (cnt_reg == 8'(PAD_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = S_PAYLOAD;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            S_PAYLOAD: begin
                if (!valid_n_i) begin
                    data_next = data_shift;
                    if (cnt_reg == 8'(DATA_W - 1)) begin
                        cnt_next   = '0;
                        push_entry = {1'b0, frame_n_i, data_shift};
                        if (can_push) begin
                            push = 1'b1;
                            if (frame_n_i) begin
                                state_next = S_IDLE;
                            end
                        end else begin
                            // Frame end sampled in this same cycle already
                            // satisfies the drop exit, so skip DROP then.
                            ovf_det    = 1'b1;
                            state_next = frame_n_i ? S_IDLE : S_DROP;
                        end
                    end else if (frame_n_i) begin
                        // Short final byte: discard the partial bits.
                        err_det    = 1'b1;
                        cnt_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end else if (frame_n_i) begin
                    // Frame closed without a qualified last bit.
                    err_det    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end
            end

            S_DROP: begin
                cnt_next = '0;
                if (frame_n_i) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, pointers and flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            busy_n_reg <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            err_reg    <= err_det;
            ovf_reg    <= ovf_reg | ovf_det;
            // Registered from the current count, so it lags the count by
            // one cycle.
            busy_n_reg <= !(count_reg >= CNT_W'(FIFO_DEPTH - 1));
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg  <= count_next;
        end
    end

    // Storage array without reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Show-ahead head; forced to zero when empty so reset reads back 0.
    assign rd_data_o = (count_reg == '0) ? '0 : mem[rd_ptr_reg];
    assign empty_o   = (count_reg == '0);
    assign err_o     = err_reg;
    assign ovf_o     = ovf_reg;
    assign busy_n_o  = busy_n_reg;

`ifdef RX_STATS_EN
    logic [15:0] pkt_cnt_reg;
    logic [7:0]  err_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else begin
            // eof sits just above the data field.
            if (push && push_entry[DATA_W]) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
            if (err_det && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign pkt_cnt_o = pkt_cnt_reg;
    assign err_cnt_o = err_cnt_reg;
`endif

endmodule
